seq_divider: RTL and testbench

- Multi-cycle signed 32-bit integer divider; the inverse-direction companion to the single-cycle ALU add/sub/shift/logic path.
- Decode issues DIV opcodes here instead of to the ALU, then stalls on `busy`.
- Writeback takes `data_result` (quotient) when `data_resultRDY` pulses.
- Internal algorithm: restoring shift-subtract, one quotient bit per clock.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 32 +++
 rtl/seq_divider.sv | 164 ++++++++++++++++
 tb/tb_seq_divider.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Constants and state encoding shared by the sequential divider and its step logic.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [DIV_WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes; produces one quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};
    assign w_fits   = (w_rem_sh >= {2'b00, i_divisor});
    // Only meaningful when the divisor fits, in which case the difference is below 2^WIDTH.
    assign w_trial  = w_rem_sh[WIDTH:0] - {1'b0, i_divisor};

    always_comb begin
        o_rem = w_rem_sh[WIDTH:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b0};
        if (w_fits) begin
            o_rem = w_trial;
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider (restoring, one quotient bit per clock).
// SEQ_DIVIDER_UNSIGNED_EN adds ctrl_unsigned for unsigned division.
//
// state | meaning
// IDLE  | waiting for ctrl_DIV; operands captured on the start edge
// CALC  | 32 shift-subtract iterations
// FIX   | apply signs, publish result, pulse data_resultRDY
// DONE  | early exit publishes here first; otherwise drop ready and go idle
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    input  logic             ctrl_unsigned,
`endif
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_early;

    logic             w_unsigned;
    logic             w_dbz;
    logic             w_ovf;
    logic             w_early;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_start;
    logic             w_step;
    logic             w_fin;
    logic             w_fin_early;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
    assign w_unsigned = ctrl_unsigned;
`else
    assign w_unsigned = 1'b0;
`endif

    assign w_dbz   = (data_operandB == '0);
    assign w_ovf   = !w_unsigned && (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
    assign w_early = w_dbz || w_ovf;
    // Negating INT_MIN yields 2^(WIDTH-1) read as unsigned, which is the wanted magnitude.
    assign w_abs_a = (!w_unsigned && data_operandA[WIDTH-1]) ? -data_operandA : data_operandA;
    assign w_abs_b = (!w_unsigned && data_operandB[WIDTH-1]) ? -data_operandB : data_operandB;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (ctrl_DIV) w_state_nxt = w_early ? DONE : CALC;
            CALC:    if (r_cnt == CNT_LAST) w_state_nxt = FIX;
            FIX:     w_state_nxt = DONE;
            DONE:    if (!r_early) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_fin       = 1'b0;
        w_fin_early = 1'b0;
        case (r_state)
            IDLE:    w_start     = ctrl_DIV;
            CALC:    w_step      = 1'b1;
            FIX:     w_fin       = 1'b1;
            DONE:    w_fin_early = r_early;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt          <= '0;
            r_rem          <= '0;
            r_quo          <= '0;
            r_div          <= '0;
            r_sign_q       <= 1'b0;
            r_sign_r       <= 1'b0;
            r_early        <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (w_start) begin
                busy     <= 1'b1;
                r_cnt    <= '0;
                r_early  <= w_early;
                r_div    <= w_abs_b;
                r_sign_q <= !w_unsigned && (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
                r_sign_r <= !w_unsigned && data_operandA[WIDTH-1];
                // Early exits park their final answer in the datapath registers.
                if (w_dbz) begin
                    r_quo <= '0;
                    r_rem <= {1'b0, data_operandA};
                end else if (w_ovf) begin
                    r_quo <= INT_MIN;
                    r_rem <= '0;
                end else begin
                    r_quo <= w_abs_a;
                    r_rem <= '0;
                end
            end
            if (w_step) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_fin) begin
                data_result    <= r_sign_q ? -r_quo : r_quo;
                data_remainder <= r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                data_exception <= 1'b0;
                data_resultRDY <= 1'b1;
                busy           <= 1'b0;
            end
            if (w_fin_early) begin
                data_result    <= r_quo;
                data_remainder <= r_rem[WIDTH-1:0];
                data_exception <= 1'b1;
                data_resultRDY <= 1'b1;
                busy           <= 1'b0;
                r_early        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against an arithmetic reference.
// Exercises the unsigned mode when SEQ_DIVIDER_UNSIGNED_EN is defined.
module tb_seq_divider;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    logic        ctrl_unsigned;
`endif
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    seq_divider dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
`ifdef SEQ_DIVIDER_UNSIGNED_EN
        .ctrl_unsigned  (ctrl_unsigned),
`endif
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic with the two exception cases.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit uns,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic e, output int lat);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'd0; r = a; e = 1'b1; lat = 1;
        end else if (uns) begin
            q = a / b; r = a % b; e = 1'b0; lat = 33;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; e = 1'b1; lat = 1;
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0; lat = 33;
        end
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit uns);
        data_operandA = a;
        data_operandB = b;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
        ctrl_unsigned = uns;
`endif
        ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
        ctrl_unsigned = $urandom_range(0, 1);
`endif
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // glitch_edge > 0 presents a spurious start that must be sampled on that CALC edge.
    task automatic finish_op(input logic [31:0] a, input logic [31:0] b, input bit uns,
                             input int glitch_edge);
        logic [31:0] eq, er;
        logic        ee;
        int          lat;
        int          n;
        ref_div(a, b, uns, eq, er, ee, lat);
        n = 0;
        while (data_resultRDY !== 1'b1 && n < 40) begin
            if (n + 1 == glitch_edge) begin
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd9;
                data_operandB = 32'd3;
            end
            @(posedge clock); #1;
            ctrl_DIV = 1'b0;
            n++;
            if (data_resultRDY !== 1'b1) check("busy_in_flight", {31'd0, busy}, 32'd1);
        end
        check("latency", n, lat);
        check("quotient", data_result, eq);
        check("remainder", data_remainder, er);
        check("exception", {31'd0, data_exception}, {31'd0, ee});
        check("busy_at_done", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        check("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit uns);
        start_op(a, b, uns);
        finish_op(a, b, uns, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          ru;
        reset         = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
        ctrl_unsigned = 1'b0;
`endif
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_remainder", data_remainder, 32'd0);
        check("reset_exception", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        #12 reset = 1'b1;
        @(posedge clock); #1;

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b0);
        run_op(32'd100, 32'hFFFF_FFF9, 1'b0);
        run_op(32'd5, 32'd0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        run_op(32'd0, 32'hFFFF_FFFF, 1'b0);

        // A start strobe while busy must not disturb the operation in flight.
        start_op(32'd100, 32'd7, 1'b0);
        finish_op(32'd100, 32'd7, 1'b0, 5);
        run_op(32'd9, 32'd3, 1'b0);
        run_op(32'd100, 32'd7, 1'b0);

        // Reset in the middle of an operation.
        start_op(32'd100, 32'd7, 1'b0);
        repeat (9) begin
            @(posedge clock); #1;
        end
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        check("midrst_result", data_result, 32'd0);
        check("midrst_remainder", data_remainder, 32'd0);
        check("midrst_exception", {31'd0, data_exception}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(posedge clock); #3;
        reset = 1'b1;
        repeat (40) begin
            @(posedge clock); #1;
            check("no_rdy_after_reset", {31'd0, data_resultRDY}, 32'd0);
        end
        run_op(32'd50, 32'd5, 1'b0);

`ifdef SEQ_DIVIDER_UNSIGNED_EN
        run_op(32'hFFFF_FFFF, 32'd2, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'hDEAD_BEEF, 32'd0, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(0, 16)) - 32'd8;
                2:       begin ra = 32'h8000_0000; rb = 32'($urandom_range(0, 2)) - 32'd1; end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
`ifdef SEQ_DIVIDER_UNSIGNED_EN
            ru = bit'($urandom_range(0, 1));
`else
            ru = 1'b0;
`endif
            run_op(ra, rb, ru);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
